ipsl_pcie_uart2apb_master: RTL and testbench
============================================

Name: ipsl_pcie_uart2apb_master

Overview:
- Byte-stream command decoder and APB initiator for the UART debug domain.
- Parses framed read/write commands from the UART receive byte stream and runs one APB transfer per frame on the uart-side APB port (p_sel/p_ce/p_we/p_strb/p_addr/p_wdata, p_rdy/p_rdata).
- That port feeds the existing APB address mux, which routes to the HSST and PCIe targets.
- Returns a status byte, plus read data, on the UART transmit byte stream.

Parameters:
- ACK_TIMEOUT, 1023: access-phase cycles to wait for i_p_rdy before aborting the transfer.
- FRAME_GAP, 65535: idle cycles allowed between bytes of a partial frame before the frame is discarded.

Ports:
- i_clk  input  1  uart-domain clock
- i_rst_n  input  1  asynchronous active-low reset
- i_rx_data  input  8  received byte
- i_rx_valid  input  1  single-cycle strobe, i_rx_data valid
- o_tx_data  output  8  response byte
- o_tx_valid  output  1  response byte valid; held until accepted
- i_tx_ready  input  1  transmitter accepts o_tx_data when o_tx_valid&i_tx_ready
- o_p_sel  output  1  APB select
- o_p_ce  output  1  APB access enable
- o_p_we  output  1  1=write, 0=read
- o_p_strb  output  4  byte strobes
- o_p_addr  output  16  address
- o_p_wdata  output  32  write data
- i_p_rdy  input  1  target ready (transfer complete)
- i_p_rdata  input  32  read data, sampled when i_p_rdy=1 in access phase
- o_busy  output  1  high from the first frame byte until the last response byte is accepted

Behaviour:
- Reset (async assert, sync deassert by i_clk): all outputs 0; state IDLE; counters 0.
- Frame format:
  - Byte0 CMD: bit7 = we, bits[3:0] = strb, bits[6:4] ignored.
  - Bytes 1-2: address, MSB first.
  - Write only: bytes 3-6, wdata MSB first.
  - Read sends strb as given; the target ignores it.
- States and transitions:
  - IDLE: any i_rx_valid byte is latched as CMD -> ADDR.
  - ADDR: collect 2 bytes -> SETUP if read, WDATA if write.
  - WDATA: collect 4 bytes -> SETUP.
  - SETUP (1 cycle): o_p_sel=1, o_p_ce=0; addr/we/strb/wdata stable -> ACCESS.
  - ACCESS: o_p_sel=1, o_p_ce=1.
    - i_p_rdy=1: capture i_p_rdata, status=0x00, drop sel/ce next cycle -> RESP.
    - Else when the wait counter reaches ACK_TIMEOUT: status=0x01, read data=0, drop sel/ce -> RESP.
  - RESP: send status byte, then (read only) 4 data bytes MSB first. Each byte is held on o_tx_data with o_tx_valid=1 until i_tx_ready. After the last accepted byte -> IDLE.
- APB output stability:
  - o_p_addr/o_p_we/o_p_strb/o_p_wdata change only in IDLE/ADDR/WDATA.
  - They hold their last values after a transfer; they are not zeroed.
- Latency: last frame byte -> o_p_sel rises the next cycle. A zero-wait target (i_p_rdy=1 in the first access cycle) gives sel high 2 cycles; first response byte valid on the cycle after sel falls.
- Wait counter:
  - Clears on entering ACCESS; increments each ACCESS cycle with i_p_rdy=0.
  - i_p_rdy=1 on the same cycle the counter reaches ACK_TIMEOUT counts as success.
  - i_p_rdy during SETUP is ignored.
- Gap counter:
  - Active in ADDR/WDATA; clears on each received byte.
  - At FRAME_GAP: discard the partial frame -> IDLE, no response, no APB activity.
- i_rx_valid during SETUP/ACCESS/RESP: byte dropped; no queuing.
- Simultaneous events:
  - Gap expiry and byte arrival on the same cycle: the byte wins and the counter clears.
  - Back-to-back frames: the next CMD byte is only accepted in IDLE, so the host must wait for the full response.
- Reset mid-transfer: sel/ce/tx_valid drop immediately (asynchronously); the frame is lost.

Test Plan:
- Write, zero-wait: rx 0x8F,0x70,0x04,0xDE,0xAD,0xBE,0xEF -> one SETUP cycle sel=1/ce=0, then sel=1/ce=1/we=1, addr=0x7004, wdata=0xDEADBEEF, strb=0xF; tx 0x00.
- Read with 3 wait states: rx 0x0F,0x10,0x20; i_p_rdy asserted in 4th access cycle with rdata=0x12345678 -> addr=0x1020, we=0; tx 0x00,0x12,0x34,0x56,0x78.
- Timeout: ACK_TIMEOUT=8, read 0x0F,0x30,0x00, i_p_rdy held 0 -> ce high exactly 8 access cycles then drops; tx 0x01,0x00,0x00,0x00,0x00.
- Frame gap: FRAME_GAP=16, rx 0x8F,0x70 then idle 16 cycles, then valid read frame 0x0F,0x70,0x00 -> first partial frame produces no APB activity; read to 0x7000 proceeds normally.
- TX backpressure: i_tx_ready low 5 cycles per byte during a read response -> each byte held stable while o_tx_valid=1; order preserved; o_busy falls only after the last byte is accepted.
- Async reset asserted during ACCESS -> o_p_sel/o_p_ce/o_tx_valid/o_busy go 0 without a clock edge; after release, a new write frame completes normally.

Source files
------------

// File: rtl/ipsl_pcie_uart2apb_master.sv
// UART byte-stream command decoder driving one APB transfer per frame.
// A status byte, plus four read-data bytes for reads, is returned on the transmit stream.
module ipsl_pcie_uart2apb_master #(
  parameter int unsigned ACK_TIMEOUT = 1023,
  parameter int unsigned FRAME_GAP   = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_p_sel,
  output logic        o_p_ce,
  output logic        o_p_we,
  output logic [3:0]  o_p_strb,
  output logic [15:0] o_p_addr,
  output logic [31:0] o_p_wdata,
  input  logic        i_p_rdy,
  input  logic [31:0] i_p_rdata,
  output logic        o_busy
);

  localparam int unsigned WW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GW = $clog2(FRAME_GAP + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(FRAME_GAP - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_WDATA  = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_ACCESS = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    tx_cnt;
  logic [31:0]   rd_buf;
  logic          collecting;
  logic          xfer_ok, xfer_to;
  logic          tx_accept, tx_last;
  logic          unused_cmd_bits;

  // Command bits [6:4] carry no meaning.
  assign unused_cmd_bits = ^i_rx_data[6:4];

  assign collecting = (state == ST_ADDR) || (state == ST_WDATA);
  assign tx_accept  = (state == ST_RESP) && o_tx_valid && i_tx_ready;
  assign tx_last    = o_p_we || (tx_cnt == 3'd4);

  always_comb begin
    state_nxt = state;
    xfer_ok   = 1'b0;
    xfer_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_rx_valid) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (i_rx_valid) begin
          if (byte_cnt == 2'd1) state_nxt = o_p_we ? ST_WDATA : ST_SETUP;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (i_rx_valid) begin
          if (byte_cnt == 2'd3) state_nxt = ST_SETUP;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        // A ready on the final wait cycle still wins over the timeout.
        if (i_p_rdy) begin
          xfer_ok   = 1'b1;
          state_nxt = ST_RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          xfer_to   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_accept && tx_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_p_sel    <= 1'b0;
      o_p_ce     <= 1'b0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_p_sel    <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
      o_p_ce     <= (state_nxt == ST_ACCESS);
      o_tx_valid <= (state_nxt == ST_RESP);
      o_busy     <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_cnt <= '0;
      gap_cnt  <= '0;
      wait_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      // Byte index restarts whenever the collecting phase changes.
      if (state_nxt != state)               byte_cnt <= '0;
      else if (collecting && i_rx_valid)    byte_cnt <= byte_cnt + 1'b1;

      if (state_nxt != state || i_rx_valid) gap_cnt <= '0;
      else if (collecting)                  gap_cnt <= gap_cnt + 1'b1;

      if (state != ST_ACCESS)               wait_cnt <= '0;
      else if (!i_p_rdy)                    wait_cnt <= wait_cnt + 1'b1;

      if (state != ST_RESP)                 tx_cnt <= '0;
      else if (tx_accept)                   tx_cnt <= tx_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_p_we    <= 1'b0;
      o_p_strb  <= '0;
      o_p_addr  <= '0;
      o_p_wdata <= '0;
      o_tx_data <= '0;
      rd_buf    <= '0;
    end else begin
      if (state == ST_IDLE && i_rx_valid) begin
        o_p_we   <= i_rx_data[7];
        o_p_strb <= i_rx_data[3:0];
      end
      if (state == ST_ADDR && i_rx_valid)  o_p_addr  <= {o_p_addr[7:0], i_rx_data};
      if (state == ST_WDATA && i_rx_valid) o_p_wdata <= {o_p_wdata[23:0], i_rx_data};

      if (xfer_ok) begin
        rd_buf    <= i_p_rdata;
        o_tx_data <= 8'h00;
      end else if (xfer_to) begin
        rd_buf    <= '0;
        o_tx_data <= 8'h01;
      end else if (tx_accept && !tx_last) begin
        o_tx_data <= rd_buf[31:24];
        rd_buf    <= {rd_buf[23:0], 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_ipsl_pcie_uart2apb_master.sv
// Self-checking bench for ipsl_pcie_uart2apb_master: directed table, corner sequences
// and random frames against a frame-level reference model.
module tb_ipsl_pcie_uart2apb_master;

  localparam int unsigned ACK = 8;
  localparam int unsigned GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        p_sel, p_ce, p_we;
  logic [3:0]  p_strb;
  logic [15:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_rdy = 1'b0;
  logic [31:0] p_rdata = '0;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [31:0] m_wdata = '0;

  typedef struct {
    logic [55:0] bytes;     // frame bytes, byte 0 in [55:48]
    int          n;
    int          wait_cyc;  // access cycle (0-based) carrying ready; -1 = never
    logic [31:0] rdata;
    int          stall;
    bit          rdy_setup;
    bit          noise;
    int          gap1;      // idle cycles inserted after byte 1
    logic [15:0] e_addr;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    int          e_ce;
    int          e_nresp;
    logic [39:0] e_resp;
  } vec_t;

  vec_t tbl [6];

  ipsl_pcie_uart2apb_master #(.ACK_TIMEOUT(ACK), .FRAME_GAP(GAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_p_sel(p_sel), .o_p_ce(p_ce), .o_p_we(p_we), .o_p_strb(p_strb),
    .o_p_addr(p_addr), .o_p_wdata(p_wdata),
    .i_p_rdy(p_rdy), .i_p_rdata(p_rdata),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [55:0] b, input int i);
    return b[55-8*i -: 8];
  endfunction

  function automatic vec_t mk(input logic [55:0] bytes, input int n, input int wait_cyc,
                              input logic [31:0] rdata, input int stall, input bit rdy_setup,
                              input bit noise, input int gap1, input logic [15:0] a,
                              input logic we, input logic [3:0] s, input logic [31:0] wd,
                              input int ce, input int nresp, input logic [39:0] resp);
    vec_t v;
    v.bytes = bytes; v.n = n; v.wait_cyc = wait_cyc; v.rdata = rdata; v.stall = stall;
    v.rdy_setup = rdy_setup; v.noise = noise; v.gap1 = gap1;
    v.e_addr = a; v.e_we = we; v.e_strb = s; v.e_wdata = wd; v.e_ce = ce;
    v.e_nresp = nresp; v.e_resp = resp;
    return v;
  endfunction

  // Frame-level reference: what one complete frame must produce.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_wd);
    vec_t r = v;
    logic [7:0] cmd = byte_of(v.bytes, 0);
    bit ok = (v.wait_cyc >= 0) && (v.wait_cyc < int'(ACK));
    r.e_we    = cmd[7];
    r.e_strb  = cmd[3:0];
    r.e_addr  = {byte_of(v.bytes, 1), byte_of(v.bytes, 2)};
    r.e_wdata = cmd[7] ? {byte_of(v.bytes, 3), byte_of(v.bytes, 4),
                          byte_of(v.bytes, 5), byte_of(v.bytes, 6)} : prev_wd;
    r.e_ce    = ok ? v.wait_cyc + 1 : int'(ACK);
    r.e_nresp = cmd[7] ? 1 : 5;
    r.e_resp  = {(ok ? 8'h00 : 8'h01), (ok ? v.rdata : 32'h0)};
    return r;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int ce_cnt = 0;
    int hold_err = 0;
    int k = 0;
    logic [7:0] held;
    for (int i = 0; i < v.n; i++) begin
      rx_data = byte_of(v.bytes, i);
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      if (i == 1) repeat (v.gap1) step();
    end
    check({tag, "_setup"}, {78'h0, p_sel, p_ce}, 80'b10);
    check({tag, "_addr"}, 80'(p_addr), 80'(v.e_addr));
    check({tag, "_we"}, 80'(p_we), 80'(v.e_we));
    check({tag, "_strb"}, 80'(p_strb), 80'(v.e_strb));
    check({tag, "_wdata"}, 80'(p_wdata), 80'(v.e_wdata));
    p_rdy = v.rdy_setup;
    p_rdata = $urandom;
    step();
    p_rdy = 1'b0;
    while (p_ce && k < int'(2*ACK + 4)) begin
      ce_cnt++;
      if (!p_sel || p_addr !== v.e_addr || p_wdata !== v.e_wdata) hold_err++;
      p_rdy = (v.wait_cyc == k);
      p_rdata = (v.wait_cyc == k) ? v.rdata : $urandom;
      if (v.noise) begin
        rx_valid = 1'($urandom);
        rx_data = 8'($urandom);
      end
      step();
      p_rdy = 1'b0;
      rx_valid = 1'b0;
      k++;
    end
    check({tag, "_ce_cycles"}, 80'(ce_cnt), 80'(v.e_ce));
    check({tag, "_post"}, {77'h0, p_sel, p_ce, tx_valid}, 80'b001);
    for (int j = 0; j < v.e_nresp; j++) begin
      held = tx_data;
      for (int s = 0; s < v.stall; s++) begin
        if (tx_valid !== 1'b1 || tx_data !== held || busy !== 1'b1) hold_err++;
        step();
      end
      check($sformatf("%s_resp%0d", tag, j), {70'h0, tx_valid, busy, tx_data},
            {70'h0, 1'b1, 1'b1, v.e_resp[39-8*j -: 8]});
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    check({tag, "_hold"}, 80'(hold_err), 80'h0);
    check({tag, "_end"}, {76'h0, tx_valid, busy, p_sel, p_ce}, 80'h0);
    m_wdata = v.e_wdata;
  endtask

  initial begin
    vec_t v;
    int sel_seen;

    tbl[0] = mk(56'h8F7004DEADBEEF, 7, 0, 32'h0, 0, 0, 0, 0,
                16'h7004, 1, 4'hF, 32'hDEADBEEF, 1, 1, 40'h00_00000000);
    tbl[1] = mk(56'h0F102000000000, 3, 3, 32'h12345678, 0, 1, 1, 0,
                16'h1020, 0, 4'hF, 32'hDEADBEEF, 4, 5, 40'h00_12345678);
    tbl[2] = mk(56'h0F300000000000, 3, -1, 32'h0, 0, 0, 0, 0,
                16'h3000, 0, 4'hF, 32'hDEADBEEF, 8, 5, 40'h01_00000000);
    tbl[3] = mk(56'h05ABCD00000000, 3, 1, 32'hCAFEF00D, 5, 1, 1, 0,
                16'hABCD, 0, 4'h5, 32'hDEADBEEF, 2, 5, 40'h00_CAFEF00D);
    tbl[4] = mk(56'hF300FF01020304, 7, 7, 32'h0, 1, 0, 0, 0,
                16'h00FF, 1, 4'h3, 32'h01020304, 8, 1, 40'h00_00000000);
    tbl[5] = mk(56'h00123400000000, 3, 8, 32'hFFFFFFFF, 0, 0, 0, 0,
                16'h1234, 0, 4'h0, 32'h01020304, 8, 5, 40'h01_00000000);

    #12;
    check("reset_outputs", {15'h0, p_sel, p_ce, p_we, p_strb, p_addr, p_wdata, tx_valid, tx_data, busy},
          80'h0);
    #5 rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Partial frame abandoned after the gap limit.
    sel_seen = 0;
    rx_data = 8'h8F; rx_valid = 1'b1; step();
    rx_data = 8'h70; step();
    rx_valid = 1'b0;
    for (int i = 0; i < int'(GAP); i++) begin
      if (i == int'(GAP) - 1) check("gap_busy_before", 80'(busy), 80'h1);
      step();
      if (p_sel) sel_seen++;
    end
    check("gap_discard", {78'h0, busy, tx_valid}, 80'h0);
    check("gap_no_apb", 80'(sel_seen), 80'h0);
    apply(model(mk(56'h0F700000000000, 3, 0, 32'hA5A55A5A, 0, 0, 0, 0,
                   16'h0, 0, 4'h0, 32'h0, 0, 0, 40'h0), m_wdata), "gap_read");
    // Byte arriving on the very cycle the gap would expire keeps the frame.
    apply(model(mk(56'h0F556600000000, 3, 2, 32'h600DF00D, 0, 0, 0, int'(GAP) - 1,
                   16'h0, 0, 4'h0, 32'h0, 0, 0, 40'h0), m_wdata), "gap_edge");

    for (int i = 0; i < 40; i++) begin
      logic we = 1'($urandom);
      logic [55:0] b = {we, 3'($urandom), 4'($urandom), 16'($urandom), 32'($urandom)};
      v = mk(b, we ? 7 : 3, ($urandom_range(0, 12) == 12) ? -1 : int'($urandom_range(0, 10)),
             $urandom, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 16'h0, 0, 4'h0, 32'h0, 0, 0, 40'h0);
      apply(model(v, m_wdata), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of an access phase.
    rx_valid = 1'b1;
    rx_data = 8'h0F; step();
    rx_data = 8'h12; step();
    rx_data = 8'h34; step();
    rx_valid = 1'b0;
    step();
    check("rst_pre_access", {78'h0, p_sel, p_ce}, 80'b11);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_drop", {76'h0, p_sel, p_ce, tx_valid, busy}, 80'h0);
    #3 rst_n = 1'b1;
    step();
    m_wdata = '0;
    apply(model(mk(56'h8A432111223344, 7, 2, 32'h0, 1, 0, 0, 0,
                   16'h0, 0, 4'h0, 32'h0, 0, 0, 40'h0), m_wdata), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
